// File: rtl/par4_pkg.sv
// Shared types and default sizing for the parabolic pulse checkers.
package par4_pkg;

    localparam int unsigned P4_DW     = 12;
    localparam int unsigned P4_CW     = 8;
    localparam int unsigned P4_AW     = 20;
    localparam int unsigned P4_NP_MAX = 255;

    // A period starts when the previous sample sits at this level and the new one leaves it.
    localparam int unsigned START_LEVEL = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        MEAS  = 2'd2
    } state_t;

endpackage

// File: rtl/par4_pulse_meter_if.sv
// Sample input and per-period measurement results of the pulse meter.
interface par4_pulse_meter_if
    import par4_pkg::*;
#(
    parameter int unsigned DW = P4_DW,
    parameter int unsigned CW = P4_CW,
    parameter int unsigned AW = P4_AW
);
    logic                 ce;
    logic [DW-1:0]        DIN;
    logic signed [DW:0]   D1;
    logic [CW-1:0]        PERIOD;
    logic [DW-1:0]        PEAK;
    logic [CW-1:0]        PEAK_IDX;
    logic [AW-1:0]        AREA;
    logic                 VLD;
    logic                 LOCK;
    logic                 ERR;

    // Sample source / result consumer side.
    modport master (
        output ce, DIN,
        input  D1, PERIOD, PEAK, PEAK_IDX, AREA, VLD, LOCK, ERR
    );

    // Meter side.
    modport slave (
        input  ce, DIN,
        output D1, PERIOD, PEAK, PEAK_IDX, AREA, VLD, LOCK, ERR
    );
endinterface

// File: rtl/par4_diff.sv
// First-difference stage: previous-sample register, signed slope and period-start detect.
module par4_diff
    import par4_pkg::*;
#(
    parameter int unsigned DW = P4_DW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic [DW-1:0]       din,
    output logic signed [DW:0]  d1,
    output logic                start_c
);

    logic [DW-1:0] prev;

    // Rising edge out of the baseline marks index 1 of a new period.
    assign start_c = (prev == DW'(START_LEVEL)) && (din != DW'(START_LEVEL));

    // Slope register; full DW+1 signed width so the difference never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
            d1   <= '0;
        end else if (ce) begin
            d1   <= $signed({1'b0, din}) - $signed({1'b0, prev});
            prev <= din;
        end
    end

endmodule

// File: rtl/par4_pulse_meter.sv
// Per-period meter for the four-segment parabolic pulse stream:
// period length, peak value/index and area, with lock and timeout flags.
module par4_pulse_meter
    import par4_pkg::*;
#(
    parameter int unsigned DW     = P4_DW,
    parameter int unsigned NP_MAX = P4_NP_MAX,
    parameter int unsigned CW     = P4_CW,
    parameter int unsigned AW     = P4_AW
) (
    input  logic              clk,
    input  logic              rst,
    par4_pulse_meter_if.slave bus
);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   peak;
    logic [CW-1:0]   pidx;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   last_period;

    logic [CW-1:0]   period_q;
    logic [DW-1:0]   peak_q;
    logic [CW-1:0]   peak_idx_q;
    logic [AW-1:0]   area_q;
    logic            vld_q;
    logic            lock_q;
    logic            err_q;

    logic signed [DW:0] d1;
    logic               start_c;

    par4_diff #(.DW(DW)) u_diff (
        .clk     (clk),
        .rst     (rst),
        .ce      (bus.ce),
        .din     (bus.DIN),
        .d1      (d1),
        .start_c (start_c)
    );

    assign bus.D1       = d1;
    assign bus.PERIOD   = period_q;
    assign bus.PEAK     = peak_q;
    assign bus.PEAK_IDX = peak_idx_q;
    assign bus.AREA     = area_q;
    assign bus.VLD      = vld_q;
    assign bus.LOCK     = lock_q;
    assign bus.ERR      = err_q;

    // Period FSM with peak/area accumulation; a start both closes the old period and opens the next.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            peak        <= '0;
            pidx        <= '0;
            acc         <= '0;
            last_period <= '0;
            period_q    <= '0;
            peak_q      <= '0;
            peak_idx_q  <= '0;
            area_q      <= '0;
            vld_q       <= 1'b0;
            lock_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            err_q <= 1'b0;
            if (bus.ce) begin
                case (state)
                    IDLE: begin
                        if (bus.DIN == DW'(START_LEVEL)) begin
                            state <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (start_c) begin
                            state <= MEAS;
                            cnt   <= CW'(1);
                            peak  <= bus.DIN;
                            pidx  <= CW'(1);
                            acc   <= AW'(bus.DIN);
                        end
                    end
                    MEAS: begin
                        if (start_c) begin
                            // Publish; a start beats a simultaneous timeout.
                            period_q    <= cnt;
                            peak_q      <= peak;
                            peak_idx_q  <= pidx;
                            area_q      <= acc;
                            vld_q       <= 1'b1;
                            lock_q      <= (cnt == last_period);
                            last_period <= cnt;
                            cnt         <= CW'(1);
                            peak        <= bus.DIN;
                            pidx        <= CW'(1);
                            acc         <= AW'(bus.DIN);
                        end else if (cnt == CW'(NP_MAX)) begin
                            // Timeout: keep published results, forget the lock reference.
                            err_q       <= 1'b1;
                            lock_q      <= 1'b0;
                            last_period <= '0;
                            state       <= IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                            acc <= acc + AW'(bus.DIN);
                            if (bus.DIN > peak) begin
                                peak <= bus.DIN;
                                pidx <= cnt + CW'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_par4_pulse_meter.sv
// Directed bench for par4_pulse_meter with hand-computed expected values.
module tb_par4_pulse_meter;

    logic clk;
    logic rst;
    int   nvec;
    int   nfail;
    int   gap;

    par4_pulse_meter_if bus ();

    par4_pulse_meter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] w6 [8];
    logic [11:0] w8 [8];
    logic [11:0] wt [8];
    int          d1_6 [6];

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One strobed sample, preceded by gap idle clocks; returns 1 time unit after the edge.
    task automatic feed(input logic [11:0] d);
        repeat (gap) begin
            bus.ce = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.ce  = 1'b1;
        bus.DIN = d;
        @(posedge clk);
        #1;
        bus.ce = 1'b0;
    endtask

    task automatic play(input logic [11:0] w [8], input int first, input int n);
        for (int i = first; i < n; i++) feed(w[i]);
    endtask

    task automatic pulse_rst();
        bus.ce = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period"}, bus.PERIOD, 0);
        check({tag, "_peak"},   bus.PEAK, 0);
        check({tag, "_pidx"},   bus.PEAK_IDX, 0);
        check({tag, "_area"},   bus.AREA, 0);
        check({tag, "_vld"},    bus.VLD, 0);
        check({tag, "_lock"},   bus.LOCK, 0);
        check({tag, "_err"},    bus.ERR, 0);
        check({tag, "_d1"},     bus.D1, 0);
    endtask

    task automatic check_pub(input string tag, input int p, input int pk, input int idx,
                             input int area, input int lock);
        check({tag, "_vld"},    bus.VLD, 1);
        check({tag, "_period"}, bus.PERIOD, p);
        check({tag, "_peak"},   bus.PEAK, pk);
        check({tag, "_pidx"},   bus.PEAK_IDX, idx);
        check({tag, "_area"},   bus.AREA, area);
        check({tag, "_lock"},   bus.LOCK, lock);
        check({tag, "_err"},    bus.ERR, 0);
    endtask

    initial begin
        nvec  = 0;
        nfail = 0;
        gap   = 0;
        w6 = '{12'd10, 12'd20, 12'd30, 12'd20, 12'd10, 12'd0, 12'd0, 12'd0};
        w8 = '{12'd10, 12'd20, 12'd30, 12'd40, 12'd30, 12'd20, 12'd10, 12'd0};
        wt = '{12'd5, 12'd9, 12'd9, 12'd4, 12'd0, 12'd0, 12'd0, 12'd0};
        d1_6 = '{10, 10, 10, -10, -10, -10};
        rst     = 1'b1;
        bus.ce  = 1'b0;
        bus.DIN = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Period-6 triangle, ce every clock.
        feed(12'd0);
        check("d1_base", bus.D1, 0);
        for (int i = 0; i < 6; i++) begin
            feed(w6[i]);
            check("d1_seq", bus.D1, d1_6[i]);
            if (i == 0) check("first_start_vld", bus.VLD, 0);
        end
        feed(12'd10);
        check_pub("p6_first", 6, 30, 3, 90, 0);
        feed(12'd20);
        check("vld_width", bus.VLD, 0);
        check("period_hold", bus.PERIOD, 6);
        play(w6, 2, 6);
        feed(12'd10);
        check_pub("p6_lock", 6, 30, 3, 90, 1);

        // Same stream, ce every third clock.
        pulse_rst();
        gap = 2;
        feed(12'd0);
        play(w6, 0, 6);
        feed(12'd10);
        check_pub("slow_first", 6, 30, 3, 90, 0);
        @(posedge clk);
        #1;
        check("slow_vld_width", bus.VLD, 0);
        check("slow_period_hold", bus.PERIOD, 6);
        check("slow_d1_hold", bus.D1, 10);
        play(w6, 1, 6);
        feed(12'd10);
        check_pub("slow_lock", 6, 30, 3, 90, 1);
        gap = 0;

        // Peak tie keeps the earlier index.
        pulse_rst();
        feed(12'd0);
        play(wt, 0, 5);
        feed(12'd5);
        check_pub("tie", 5, 9, 2, 27, 0);

        // Period change 6 -> 8 drops lock, next equal period relocks.
        pulse_rst();
        feed(12'd0);
        play(w6, 0, 6);
        play(w6, 0, 6);
        play(w6, 0, 6);
        play(w8, 0, 8);
        feed(12'd10);
        check_pub("chg8", 8, 40, 4, 160, 0);
        play(w8, 1, 8);
        feed(12'd10);
        check_pub("relock8", 8, 40, 4, 160, 1);

        // Constant input after lock: timeout once cnt sits at 255.
        for (int i = 0; i < 254; i++) feed(12'd7);
        check("err_not_early", bus.ERR, 0);
        feed(12'd7);
        check("timeout_err", bus.ERR, 1);
        check("timeout_lock", bus.LOCK, 0);
        check("timeout_period_hold", bus.PERIOD, 8);
        check("timeout_vld", bus.VLD, 0);
        feed(12'd7);
        check("err_width", bus.ERR, 0);
        feed(12'd0);
        play(w8, 0, 8);
        feed(12'd10);
        check_pub("after_err", 8, 40, 4, 160, 0);

        // Reset mid-period discards the partial measurement.
        feed(12'd20);
        feed(12'd30);
        pulse_rst();
        check_zero("midrst");
        feed(12'd0);
        feed(12'd10);
        check("midrst_no_vld", bus.VLD, 0);
        play(w6, 1, 6);
        feed(12'd10);
        check_pub("post_rst", 6, 30, 3, 90, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
